// File: rtl/reaction_stats_timer_if.sv
// Pin bundle between the reaction-timer core and the board-level logic.
//   start_btn, stop_btn : raw asynchronous push buttons
//   show_sel            : display source while idle or showing a result
//   led                 : reaction stimulus
//   digit3..digit0      : 4-bit digit codes to the 7-segment muxer, digit3 leftmost
interface reaction_stats_timer_if;
   logic       start_btn;
   logic       stop_btn;
   logic [1:0] show_sel;
   logic       led;
   logic [3:0] digit3;
   logic [3:0] digit2;
   logic [3:0] digit1;
   logic [3:0] digit0;

   modport master (
      output start_btn, stop_btn, show_sel,
      input  led, digit3, digit2, digit1, digit0
   );

   modport slave (
      input  start_btn, stop_btn, show_sel,
      output led, digit3, digit2, digit1, digit0
   );
endinterface

// File: rtl/reaction_stats_timer.sv
// Reaction-time tester core. After a pseudo-random delay the LED lights and the
// core counts milliseconds until stop. False starts and timeouts are flagged and
// the last ROUNDS results are kept for a running average and a best time.
// Ports:
//   clock    : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of reaction_stats_timer_if (buttons, show_sel, led, digits)
// Digit codes: 0-9, 10 'H', 11 'I', 12 '-', 13 'E', 15 blank.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset, shows HI until a display source is selected
// WAIT   | random delay running, display ----
// TIMING | LED on, ms counter running and shown live
// RESULT | reaction recorded, display chosen by show_sel
// FOUL   | stop pressed during WAIT, display ----
// TOUT   | no stop within TIMEOUT_MS, display E---
module reaction_stats_timer #(
   parameter int TICK_DIV        = 50000,
   parameter int MIN_DELAY_MS    = 1000,
   parameter int DELAY_SPAN_LOG2 = 11,
   parameter int TIMEOUT_MS      = 9999,
   parameter int ROUNDS_LOG2     = 2
) (
   input logic                   clock,
   input logic                   reset_n,
   reaction_stats_timer_if.slave bus
);

   localparam int ROUNDS = 2 ** ROUNDS_LOG2;
   localparam int PW     = $clog2(TICK_DIV);
   localparam int SW     = 14 + ROUNDS_LOG2;
   localparam int CW     = ROUNDS_LOG2 + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_TIMING = 3'd2;
   localparam logic [2:0] S_RESULT = 3'd3;
   localparam logic [2:0] S_FOUL   = 3'd4;
   localparam logic [2:0] S_TOUT   = 3'd5;

   localparam logic [1:0] M_DASH = 2'd0;
   localparam logic [1:0] M_NUM  = 2'd1;
   localparam logic [1:0] M_ERR  = 2'd2;

   localparam logic [15:0] DISP_HI   = 16'hABFF;
   localparam logic [15:0] DISP_DASH = 16'hCCCC;
   localparam logic [15:0] DISP_ERR  = 16'hDCCC;

   logic [2:0]    state, state_nx, prev_state;
   logic [2:0]    start_sh, stop_sh;
   logic          start_pulse, stop_pulse;
   logic [15:0]   lfsr;
   logic [PW-1:0] pre;
   logic          ms_tick, clr_pre, state_entry, rec_en;
   logic [15:0]   delay;
   logic [13:0]   ms_cnt;

   logic [13:0]   hist [ROUNDS];
   logic [ROUNDS_LOG2-1:0] wr_ptr;
   logic [CW-1:0] valid_cnt;
   logic [SW-1:0] sum;
   logic [13:0]   best, last, rounds;
   logic          full, has_rec;

   logic [1:0]    sel_q;
   logic          conv_go;
   logic [13:0]   src_val, bin;
   logic [1:0]    src_mode, mode_q;
   logic [15:0]   bcd, bcd_adj, digits_q;
   logic [3:0]    step;
   logic          busy;

   // Buttons: two synchroniser flops, a history flop for edge detection and a
   // registered pulse, so a pin edge shows up as a pulse three cycles later.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         start_sh    <= '0;
         stop_sh     <= '0;
         start_pulse <= 1'b0;
         stop_pulse  <= 1'b0;
      end else begin
         start_sh    <= {start_sh[1:0], bus.start_btn};
         stop_sh     <= {stop_sh[1:0], bus.stop_btn};
         start_pulse <= start_sh[1] & ~start_sh[2];
         stop_pulse  <= stop_sh[1] & ~stop_sh[2];
      end
   end

   // Galois LFSR, taps 16,14,13,11, free running.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) lfsr <= 16'hACE1;
      else          lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_RESULT, S_FOUL, S_TOUT:
            if (start_pulse) state_nx = S_WAIT;
         S_WAIT:
            if (stop_pulse)        state_nx = S_FOUL;
            else if (delay == '0)  state_nx = S_TIMING;
         S_TIMING:
            // stop takes priority, so a stop on the timeout cycle records TIMEOUT_MS
            if (stop_pulse)                        state_nx = S_RESULT;
            else if (ms_cnt == 14'(TIMEOUT_MS))    state_nx = S_TOUT;
         default: state_nx = S_IDLE;
      endcase
   end

   assign clr_pre     = (state_nx != state) && (state_nx == S_WAIT || state_nx == S_TIMING);
   assign ms_tick     = (pre == PW'(TICK_DIV - 1));
   assign state_entry = (state != prev_state);
   assign rec_en      = state_entry && (state == S_RESULT);
   assign full        = (valid_cnt == CW'(ROUNDS));
   assign has_rec     = (valid_cnt != '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         prev_state <= S_IDLE;
         pre        <= '0;
         delay      <= '0;
         ms_cnt     <= '0;
      end else begin
         state      <= state_nx;
         prev_state <= state;

         if (clr_pre || ms_tick) pre <= '0;
         else                    pre <= pre + 1'b1;

         if (state != S_WAIT && state_nx == S_WAIT)
            delay <= 16'(MIN_DELAY_MS) + 16'(lfsr[DELAY_SPAN_LOG2-1:0]);
         else if (state == S_WAIT && ms_tick && delay != '0)
            delay <= delay - 1'b1;

         if (state != S_TIMING && state_nx == S_TIMING)
            ms_cnt <= '0;
         else if (state == S_TIMING && state_nx == S_TIMING && ms_tick)
            ms_cnt <= ms_cnt + 1'b1;
      end
   end

   // Statistics are written on the first RESULT cycle; ms_cnt is frozen there.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ROUNDS; i++) hist[i] <= '0;
         wr_ptr    <= '0;
         valid_cnt <= '0;
         sum       <= '0;
         best      <= 14'd9999;
         last      <= '0;
         rounds    <= '0;
      end else if (rec_en) begin
         hist[wr_ptr] <= ms_cnt;
         wr_ptr       <= wr_ptr + 1'b1;
         sum          <= sum + SW'(ms_cnt) - (full ? SW'(hist[wr_ptr]) : SW'(0));
         if (!full)        valid_cnt <= valid_cnt + 1'b1;
         if (ms_cnt < best) best     <= ms_cnt;
         last         <= ms_cnt;
         rounds       <= (rounds == 14'd9999) ? 14'd0 : rounds + 1'b1;
      end
   end

   always_comb begin
      src_val  = '0;
      src_mode = M_DASH;
      case (state)
         S_TIMING: begin
            src_val  = ms_cnt;
            src_mode = M_NUM;
         end
         S_TOUT: src_mode = M_ERR;
         S_IDLE, S_RESULT:
            case (bus.show_sel)
               2'd0: if (has_rec) begin src_val = last; src_mode = M_NUM; end
               2'd1: if (full) begin src_val = sum[SW-1:ROUNDS_LOG2]; src_mode = M_NUM; end
               2'd2: if (has_rec) begin src_val = best; src_mode = M_NUM; end
               default: begin src_val = rounds; src_mode = M_NUM; end
            endcase
         default: src_mode = M_DASH;
      endcase
   end

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 4; i++)
         if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
   end

   // Conversion requests are delayed one cycle so that a conversion started on
   // RESULT entry samples the statistics after they have been written.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sel_q    <= 2'd0;
         conv_go  <= 1'b0;
         bin      <= '0;
         bcd      <= '0;
         step     <= '0;
         busy     <= 1'b0;
         mode_q   <= M_DASH;
         digits_q <= DISP_HI;
      end else begin
         sel_q   <= bus.show_sel;
         conv_go <= state_entry || (state == S_TIMING && ms_tick) || (bus.show_sel != sel_q);
         if (conv_go) begin
            bin    <= src_val;
            bcd    <= '0;
            step   <= 4'd14;
            busy   <= 1'b1;
            mode_q <= src_mode;
         end else if (busy) begin
            if (step != '0) begin
               bcd  <= {bcd_adj[14:0], bin[13]};
               bin  <= {bin[12:0], 1'b0};
               step <= step - 1'b1;
            end else begin
               busy <= 1'b0;
               case (mode_q)
                  M_NUM:   digits_q <= bcd;
                  M_ERR:   digits_q <= DISP_ERR;
                  default: digits_q <= DISP_DASH;
               endcase
            end
         end
      end
   end

   assign bus.led    = (state == S_TIMING);
   assign bus.digit3 = digits_q[15:12];
   assign bus.digit2 = digits_q[11:8];
   assign bus.digit1 = digits_q[7:4];
   assign bus.digit0 = digits_q[3:0];

endmodule
